// File: rtl/gpr_writeback_queue.sv
// In-order writeback FIFO feeding the three register_file write ports, with a pending-GPR mask.
// Optional forwarding lookup (fwd_sr/fwd_hit/fwd_data) is enabled by defining GPR_WB_FWD_EN.
module gpr_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_v,
  output logic        ex_ready,
  input  logic [2:0]  ex_we,
  input  logic [2:0]  ex_dr0,
  input  logic [2:0]  ex_dr1,
  input  logic [2:0]  ex_dr2,
  input  logic [1:0]  ex_wsz0,
  input  logic [1:0]  ex_wsz1,
  input  logic [1:0]  ex_wsz2,
  input  logic [31:0] ex_res0,
  input  logic [31:0] ex_res1,
  input  logic [31:0] ex_res2,
  input  logic        wb_hold,
  input  logic        flush,
  output logic        we0,
  output logic        we1,
  output logic        we2,
  output logic [2:0]  wrgpr0,
  output logic [2:0]  wrgpr1,
  output logic [2:0]  wrgpr2,
  output logic [1:0]  gprwe0,
  output logic [1:0]  gprwe1,
  output logic [1:0]  gprwe2,
  output logic [31:0] gpr_din0,
  output logic [31:0] gpr_din1,
  output logic [31:0] gpr_din2,
  output logic [7:0]  pend_mask,
  output logic        dup_err
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [2:0]  fwd_sr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2:0]       q_we  [DEPTH];
  logic [2:0][2:0]  q_dr  [DEPTH];
  logic [2:0][1:0]  q_wsz [DEPTH];
  logic [2:0][31:0] q_res [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, idx;
  logic [CW-1:0] count, count_nxt;

  logic [2:0]       o_we;
  logic [2:0][2:0]  o_dr;
  logic [2:0][1:0]  o_wsz;
  logic [2:0][31:0] o_res;

  logic [2:0]       in_we, e_we;
  logic [2:0][2:0]  in_dr, e_dr;
  logic [2:0][1:0]  in_wsz;
  logic [2:0][31:0] in_res;
  logic             dup_hit, transfer, push, pop;
  logic [7:0]       pend_nxt;

  function automatic logic [31:0] size_mask(input logic [1:0] wsz, input logic [31:0] d);
    case (wsz)
      2'd3:    return d;
      2'd2:    return {16'h0000, d[15:0]};
      default: return {24'h000000, d[7:0]};
    endcase
  endfunction

  assign ex_ready = (count < CW'(DEPTH));

  // Entries are stored already deduplicated and size-masked so the issue path is a plain copy.
  always_comb begin
    in_dr  = {ex_dr2, ex_dr1, ex_dr0};
    in_wsz = {ex_wsz2, ex_wsz1, ex_wsz0};
    in_res = {size_mask(ex_wsz2, ex_res2), size_mask(ex_wsz1, ex_res1), size_mask(ex_wsz0, ex_res0)};
    in_we  = ex_we;
    if (ex_we[0] && ex_we[1] && (ex_dr0 == ex_dr1)) in_we[1] = 1'b0;
    if (ex_we[2] && ((ex_we[0] && (ex_dr0 == ex_dr2)) || (ex_we[1] && (ex_dr1 == ex_dr2))))
      in_we[2] = 1'b0;
    dup_hit = (in_we != ex_we);
  end

  always_comb begin
    transfer = ex_v & ex_ready;
    push     = transfer & ~flush;
    pop      = (count != '0) & ~wb_hold;
    if (flush) begin
      count_nxt = '0;
      rd_nxt    = '0;
      wr_nxt    = '0;
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
      rd_nxt    = rd_ptr + AW'(pop);
      wr_nxt    = wr_ptr + AW'(push);
    end
  end

  // Mask reflects post-edge contents: surviving entries (incl. the one being pushed) plus the new issue.
  always_comb begin
    pend_nxt = '0;
    idx      = '0;
    e_we     = '0;
    e_dr     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_nxt + AW'(k);
      if (CW'(k) < count_nxt) begin
        e_we = q_we[idx];
        e_dr = q_dr[idx];
        if (push && (idx == wr_ptr)) begin
          e_we = in_we;
          e_dr = in_dr;
        end
        for (int unsigned s = 0; s < 3; s++)
          if (e_we[s]) pend_nxt[e_dr[s]] = 1'b1;
      end
    end
    if (pop)
      for (int unsigned s = 0; s < 3; s++)
        if (q_we[rd_ptr][s]) pend_nxt[q_dr[rd_ptr][s]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        q_we[k]  <= '0;
        q_dr[k]  <= '0;
        q_wsz[k] <= '0;
        q_res[k] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_we      <= '0;
      o_dr      <= '0;
      o_wsz     <= '0;
      o_res     <= '0;
      pend_mask <= '0;
      dup_err   <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      pend_mask <= pend_nxt;
      dup_err   <= dup_err | (transfer & dup_hit);
      if (push) begin
        q_we[wr_ptr]  <= in_we;
        q_dr[wr_ptr]  <= in_dr;
        q_wsz[wr_ptr] <= in_wsz;
        q_res[wr_ptr] <= in_res;
      end
      if (pop) begin
        o_we  <= q_we[rd_ptr];
        o_dr  <= q_dr[rd_ptr];
        o_wsz <= q_wsz[rd_ptr];
        o_res <= q_res[rd_ptr];
      end else begin
        o_we  <= '0;
      end
    end
  end

  assign {we2, we1, we0}             = o_we;
  assign {wrgpr2, wrgpr1, wrgpr0}    = o_dr;
  assign {gprwe2, gprwe1, gprwe0}    = o_wsz;
  assign {gpr_din2, gpr_din1, gpr_din0} = o_res;

`ifdef GPR_WB_FWD_EN
  logic [AW-1:0] fidx;

  // Scan oldest (issuing) to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fidx     = '0;
    for (int unsigned s = 0; s < 3; s++)
      if (o_we[s] && (o_wsz[s] == 2'd3) && (o_dr[s] == fwd_sr)) begin
        fwd_hit  = 1'b1;
        fwd_data = o_res[s];
      end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr + AW'(k);
      if (CW'(k) < count)
        for (int unsigned s = 0; s < 3; s++)
          if (q_we[fidx][s] && (q_wsz[fidx][s] == 2'd3) && (q_dr[fidx][s] == fwd_sr)) begin
            fwd_hit  = 1'b1;
            fwd_data = q_res[fidx][s];
          end
    end
  end
`endif
endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Randomized self-checking bench for gpr_writeback_queue against a queue-based behavioural model.
module tb_gpr_writeback_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_v, wb_hold, flush;
  logic [2:0]  ex_we;
  logic [2:0]  dr_i  [3];
  logic [1:0]  wsz_i [3];
  logic [31:0] res_i [3];
  logic        ex_ready, we0, we1, we2, dup_err;
  logic [2:0]  wrgpr0, wrgpr1, wrgpr2;
  logic [1:0]  gprwe0, gprwe1, gprwe2;
  logic [31:0] gpr_din0, gpr_din1, gpr_din2;
  logic [7:0]  pend_mask;

  always #5 clk = ~clk;

  gpr_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_v(ex_v), .ex_ready(ex_ready), .ex_we(ex_we),
    .ex_dr0(dr_i[0]), .ex_dr1(dr_i[1]), .ex_dr2(dr_i[2]),
    .ex_wsz0(wsz_i[0]), .ex_wsz1(wsz_i[1]), .ex_wsz2(wsz_i[2]),
    .ex_res0(res_i[0]), .ex_res1(res_i[1]), .ex_res2(res_i[2]),
    .wb_hold(wb_hold), .flush(flush),
    .we0(we0), .we1(we1), .we2(we2),
    .wrgpr0(wrgpr0), .wrgpr1(wrgpr1), .wrgpr2(wrgpr2),
    .gprwe0(gprwe0), .gprwe1(gprwe1), .gprwe2(gprwe2),
    .gpr_din0(gpr_din0), .gpr_din1(gpr_din1), .gpr_din2(gpr_din2),
    .pend_mask(pend_mask), .dup_err(dup_err)
  );

  typedef struct packed {
    logic [2:0]       we;
    logic [2:0][2:0]  dr;
    logic [2:0][1:0]  wsz;
    logic [2:0][31:0] d;
  } ent_t;

  ent_t        m_q [$];
  ent_t        m_out;
  logic        m_dup;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = '0;
    m_dup = 1'b0;
  endtask

  task automatic idle();
    ex_v = 1'b0; ex_we = '0; wb_hold = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dr_i[i] = '0; wsz_i[i] = '0; res_i[i] = '0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] p;
    p = '0;
    foreach (m_q[k])
      for (int s = 0; s < 3; s++)
        if (m_q[k].we[s]) p[m_q[k].dr[s]] = 1'b1;
    for (int s = 0; s < 3; s++)
      if (m_out.we[s]) p[m_out.dr[s]] = 1'b1;
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, (m_q.size() < DEPTH)});
    chk("we", {29'd0, we2, we1, we0}, {29'd0, m_out.we});
    chk("wrgpr", {23'd0, wrgpr2, wrgpr1, wrgpr0}, {23'd0, m_out.dr});
    chk("gprwe", {26'd0, gprwe2, gprwe1, gprwe0}, {26'd0, m_out.wsz});
    chk("gpr_din0", gpr_din0, m_out.d[0]);
    chk("gpr_din1", gpr_din1, m_out.d[1]);
    chk("gpr_din2", gpr_din2, m_out.d[2]);
    chk("pend_mask", {24'd0, pend_mask}, {24'd0, p});
    chk("dup_err", {31'd0, dup_err}, {31'd0, m_dup});
  endtask

  // One clock: predict from the rules, advance, then compare every output.
  task automatic cyc();
    ent_t e;
    bit   rdy, pp;
    e   = '0;
    rdy = (m_q.size() < DEPTH);
    pp  = (m_q.size() > 0) && !wb_hold;
    if (ex_v && rdy) begin
      for (int i = 0; i < 3; i++) begin
        e.we[i]  = ex_we[i];
        e.dr[i]  = dr_i[i];
        e.wsz[i] = wsz_i[i];
        for (int j = 0; j < i; j++)
          if (ex_we[j] && ex_we[i] && dr_i[j] == dr_i[i]) e.we[i] = 1'b0;
        if (wsz_i[i] == 2'd3)      e.d[i] = res_i[i];
        else if (wsz_i[i] == 2'd2) e.d[i] = res_i[i] & 32'h0000FFFF;
        else                       e.d[i] = res_i[i] & 32'h000000FF;
      end
      if (e.we != ex_we) m_dup = 1'b1;
    end
    if (pp) m_out = m_q.pop_front();
    else    m_out.we = '0;
    if (flush) m_q.delete();
    else if (ex_v && rdy) m_q.push_back(e);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_we", {29'd0, we2, we1, we0}, 32'd0);
    chk("rst_pend", {24'd0, pend_mask}, 32'd0);
    chk("rst_din0", gpr_din0, 32'd0);
    rst_n = 1'b1;

    // Basic push/issue latency
    ex_v = 1'b1; ex_we = 3'b001; dr_i[0] = 3'd3; wsz_i[0] = 2'd3; res_i[0] = 32'hDEADBEEF;
    cyc();
    chk("push_pend", {24'd0, pend_mask}, 32'h08);
    chk("push_we0", {31'd0, we0}, 32'd0);
    idle();
    cyc();
    chk("issue_we0", {31'd0, we0}, 32'd1);
    chk("issue_wrgpr0", {29'd0, wrgpr0}, 32'd3);
    chk("issue_din0", gpr_din0, 32'hDEADBEEF);
    chk("issue_pend", {24'd0, pend_mask}, 32'h08);
    cyc();
    chk("after_we0", {31'd0, we0}, 32'd0);
    chk("after_pend", {24'd0, pend_mask}, 32'd0);
    chk("after_din0_hold", gpr_din0, 32'hDEADBEEF);

    // Size masking
    ex_v = 1'b1; ex_we = 3'b001; dr_i[0] = 3'd1; wsz_i[0] = 2'd0; res_i[0] = 32'h12345678;
    cyc();
    idle();
    cyc();
    chk("mask8", gpr_din0, 32'h00000078);
    ex_v = 1'b1; ex_we = 3'b001; dr_i[0] = 3'd1; wsz_i[0] = 2'd2; res_i[0] = 32'h12345678;
    cyc();
    idle();
    cyc();
    chk("mask16", gpr_din0, 32'h00005678);
    cyc();

    // Hold until full, then drain in order
    wb_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ex_v = 1'b1; ex_we = 3'b001; dr_i[0] = 3'(k); wsz_i[0] = 2'd3; res_i[0] = 32'(100 + k);
      cyc();
      if (k == 3) chk("full_ready", {31'd0, ex_ready}, 32'd0);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("drain_we0", {31'd0, we0}, 32'd1);
      chk("drain_order", {29'd0, wrgpr0}, 32'(k));
      if (k == 0) chk("drain_ready", {31'd0, ex_ready}, 32'd1);
    end
    cyc();
    chk("drain_done", {31'd0, we0}, 32'd0);

    // Duplicate destinations inside one entry
    ex_v = 1'b1; ex_we = 3'b111;
    dr_i[0] = 3'd2; dr_i[1] = 3'd2; dr_i[2] = 3'd5;
    wsz_i[0] = 2'd3; wsz_i[1] = 2'd3; wsz_i[2] = 2'd3;
    res_i[0] = 32'h11; res_i[1] = 32'h22; res_i[2] = 32'h55;
    cyc();
    idle();
    cyc();
    chk("dup_we", {29'd0, we2, we1, we0}, 32'b101);
    chk("dup_wrgpr0", {29'd0, wrgpr0}, 32'd2);
    chk("dup_wrgpr2", {29'd0, wrgpr2}, 32'd5);
    chk("dup_err_set", {31'd0, dup_err}, 32'd1);
    cyc();
    cyc();
    chk("dup_err_sticky", {31'd0, dup_err}, 32'd1);

    // Flush of held entries, with a same-cycle push
    wb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ex_v = 1'b1; ex_we = 3'b001; dr_i[0] = 3'(4 + k); wsz_i[0] = 2'd3; res_i[0] = 32'(k);
      cyc();
    end
    dr_i[0] = 3'd7;
    flush = 1'b1;
    cyc();
    chk("flush_pend", {24'd0, pend_mask}, 32'd0);
    chk("flush_ready", {31'd0, ex_ready}, 32'd1);
    idle();
    cyc();
    chk("flush_no_we", {29'd0, we2, we1, we0}, 32'd0);
    cyc();
    chk("flush_no_we2", {29'd0, we2, we1, we0}, 32'd0);

    // Random traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      ex_v    = ($urandom_range(0, 99) < 60);
      ex_we   = 3'($urandom);
      wb_hold = ($urandom_range(0, 99) < 30);
      flush   = ($urandom_range(0, 99) < 4);
      for (int i = 0; i < 3; i++) begin
        dr_i[i]  = 3'($urandom_range(0, 7));
        wsz_i[i] = 2'($urandom);
        res_i[i] = $urandom;
      end
      if (n == 1500) begin
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", {31'd0, ex_ready}, 32'd1);
        chk("midrst_we", {29'd0, we2, we1, we0}, 32'd0);
        chk("midrst_pend", {24'd0, pend_mask}, 32'd0);
        chk("midrst_dup", {31'd0, dup_err}, 32'd0);
        chk("midrst_din1", gpr_din1, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
